// File: rtl/acc_pkg.sv
// Shared constants, FSM state encoding and result-width reduction for the MAC engine.
// Build option ACC_SATURATE_EN: results saturate at 2^DATA_W-1 instead of wrapping.
package acc_pkg;

    localparam int ACC_N      = 32;
    localparam int ACC_DATA_W = 8;
    localparam int ACC_IDX_W  = $clog2(ACC_N);
    localparam int ACC_ADDR_W = 2 * ACC_IDX_W;
    localparam int ACC_ACC_W  = 2 * ACC_DATA_W + ACC_IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        WRITE,
        DONE
    } acc_state_e;

    // Operates on a wide container so any accumulator/result width pair can use it.
    function automatic logic [63:0] acc_reduce(input logic [63:0] acc, input int unsigned data_w);
        logic [63:0] max_v;
        max_v = (64'd1 << data_w) - 64'd1;
`ifdef ACC_SATURATE_EN
        return (acc > max_v) ? max_v : acc;
`else
        return acc & max_v;
`endif
    endfunction

endpackage

// File: rtl/acc_if.sv
// Operand read port (A/B, 1-cycle read latency) and C byte write port of the MAC engine.
// Master side is the engine; slave side is the operand/result buffer owner.
interface acc_if
    import acc_pkg::*;
#(
    parameter int ADDR_W = ACC_ADDR_W,
    parameter int DATA_W = ACC_DATA_W
) ();

    logic              rd_en;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;

    modport master (
        output rd_en, a_addr, b_addr, c_we, c_addr, c_data,
        input  a_data, b_data
    );

    modport slave (
        input  rd_en, a_addr, b_addr, c_we, c_addr, c_data,
        output a_data, b_data
    );

endinterface

// File: rtl/acc_addr_gen.sv
// Nested i/j/k loop counters with wrap flags and row-major A/B/C address formation.
// Latency: addresses are combinational from the counters; counters step on the cycle after a strobe.
// Backpressure: none; steps only when the FSM strobes k_inc / elem_adv.
module acc_addr_gen
    import acc_pkg::*;
#(
    parameter  int N      = ACC_N,
    localparam int IDX_W  = $clog2(N),
    localparam int ADDR_W = 2 * IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              k_inc,
    input  logic              elem_adv,
    output logic              k_first,
    output logic              k_last,
    output logic              elem_last,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic [ADDR_W-1:0] c_addr
);

    logic [IDX_W-1:0] i_q, j_q, k_q;
    logic             i_last, j_last;

    assign k_first   = (k_q == '0);
    assign k_last    = (k_q == IDX_W'(N - 1));
    assign j_last    = (j_q == IDX_W'(N - 1));
    assign i_last    = (i_q == IDX_W'(N - 1));
    assign elem_last = i_last & j_last;

    // N is a power of two, so row*N+col is a plain concatenation.
    assign a_addr = {i_q, k_q};
    assign b_addr = {k_q, j_q};
    assign c_addr = {i_q, j_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else if (clr) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else begin
            if (k_inc) begin
                k_q <= k_q + 1'b1;
            end
            if (elem_adv) begin
                k_q <= '0;
                j_q <= j_q + 1'b1;
                if (j_last) begin
                    i_q <= i_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/acc_mac_engine.sv
// Sequential C = A*B engine: one dot product per element, result written through the C port.
// Latency: N+2 cycles per element, N*N*(N+2) per matrix, done one cycle after the last write.
// Backpressure: none; operands must return exactly one cycle after rd_en. ACC_SATURATE_EN selects saturation.
module acc_mac_engine
    import acc_pkg::*;
#(
    parameter int N      = ACC_N,
    parameter int DATA_W = ACC_DATA_W
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  start,
    output logic  busy,
    output logic  done,
    acc_if.master mem
);

    localparam int IDX_W  = $clog2(N);
    localparam int ADDR_W = 2 * IDX_W;
    localparam int ACC_W  = 2 * DATA_W + IDX_W;

    acc_state_e          state_q, state_d;
    logic                run_clr, rd_en, c_we;
    logic                k_first, k_last, elem_last;
    logic [ADDR_W-1:0]   a_addr, b_addr, c_addr;
    logic                rd_q, first_q;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    acc_q;

    acc_addr_gen #(.N(N)) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (run_clr),
        .k_inc     (rd_en),
        .elem_adv  (c_we),
        .k_first   (k_first),
        .k_last    (k_last),
        .elem_last (elem_last),
        .a_addr    (a_addr),
        .b_addr    (b_addr),
        .c_addr    (c_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_clr = 1'b0;
        rd_en   = 1'b0;
        c_we    = 1'b0;
        done    = 1'b0;
        busy    = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    run_clr = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                rd_en = 1'b1;
                if (k_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: state_d = WRITE;
            WRITE: begin
                c_we    = 1'b1;
                state_d = elem_last ? DONE : RUN;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign prod = (2*DATA_W)'(mem.a_data) * (2*DATA_W)'(mem.b_data);

    // rd_q/first_q line the accumulate step up with the operand that returns a cycle after rd_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= 1'b0;
            first_q <= 1'b0;
            acc_q   <= '0;
        end else begin
            rd_q    <= rd_en;
            first_q <= rd_en & k_first;
            if (c_we) begin
                acc_q <= '0;
            end else if (rd_q) begin
                acc_q <= first_q ? ACC_W'(prod) : acc_q + ACC_W'(prod);
            end
        end
    end

    assign mem.rd_en  = rd_en;
    assign mem.a_addr = a_addr;
    assign mem.b_addr = b_addr;
    assign mem.c_we   = c_we;
    assign mem.c_addr = c_we ? c_addr : '0;
    assign mem.c_data = c_we ? DATA_W'(acc_reduce(64'(acc_q), DATA_W)) : '0;

endmodule

// File: tb/tb_acc_mac_engine.sv
// Directed bench: a 4x4 engine driven from a vector table plus multi-cycle corner sequences,
// and one full-size 32x32 run with all-255 operands.
module tb_acc_mac_engine;
    import acc_pkg::*;

    localparam int NS    = 4;
    localparam int RUN4  = NS * NS * (NS + 2) + 1;
    localparam int RUN32 = ACC_N * ACC_N * (ACC_N + 2) + 1;
`ifdef ACC_SATURATE_EN
    localparam int E255_4  = 255;
    localparam int E1600_4 = 255;
    localparam int E255_32 = 255;
`else
    localparam int E255_4  = 4;
    localparam int E1600_4 = 64;
    localparam int E255_32 = 32;
`endif

    typedef struct {
        int         a_mode;   // 0 fill, 1 identity, 2 row+col
        logic [7:0] a_val;
        int         b_mode;
        logic [7:0] b_val;
        int         exp;      // -1: C must equal B
    } vec_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic start4 = 1'b0;
    logic start32 = 1'b0;
    logic busy4, done4, busy32, done32;

    always #5 clk = ~clk;

    acc_if #(.ADDR_W(4), .DATA_W(8)) m4 ();
    acc_if #(.ADDR_W(ACC_ADDR_W), .DATA_W(8)) m32 ();

    acc_mac_engine #(.N(NS), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4), .mem(m4)
    );

    acc_mac_engine #(.N(ACC_N), .DATA_W(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .busy(busy32), .done(done32), .mem(m32)
    );

    logic [7:0] a_mem [NS*NS];
    logic [7:0] b_mem [NS*NS];
    logic [7:0] a_q, b_q;

    always @(posedge clk) begin
        if (m4.rd_en) begin
            a_q <= a_mem[m4.a_addr];
            b_q <= b_mem[m4.b_addr];
        end
    end
    assign m4.a_data  = a_q;
    assign m4.b_data  = b_q;
    assign m32.a_data = 8'hFF;
    assign m32.b_data = 8'hFF;

    int         wr4 = 0, order4 = 0, overlap4 = 0, done4_cnt = 0, busy4_cnt = 0, next4 = 0;
    logic [7:0] c_got [NS*NS];
    int         wr32 = 0, bad32 = 0, done32_cnt = 0, busy32_cnt = 0, next32 = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            next4  = 0;
            next32 = 0;
        end
        if (m4.c_we) begin
            wr4++;
            if (m4.c_addr !== 4'(next4)) order4++;
            c_got[m4.c_addr] = m4.c_data;
            next4 = (next4 + 1) % (NS * NS);
        end
        if (m4.c_we && m4.rd_en) overlap4++;
        if (done4) done4_cnt++;
        if (busy4) busy4_cnt++;
        if (m32.c_we) begin
            wr32++;
            if (m32.c_data !== 8'(E255_32) || m32.c_addr !== ACC_ADDR_W'(next32)) bad32++;
            next32++;
        end
        if (done32) done32_cnt++;
        if (busy32) busy32_cnt++;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [7:0] elem(input int mode, input logic [7:0] val, input int r, input int c);
        case (mode)
            0:       return val;
            1:       return (r == c) ? 8'd1 : 8'd0;
            default: return 8'(r + c);
        endcase
    endfunction

    task automatic load(input vec_t v);
        for (int r = 0; r < NS; r++) begin
            for (int c = 0; c < NS; c++) begin
                a_mem[r*NS+c] = elem(v.a_mode, v.a_val, r, c);
                b_mem[r*NS+c] = elem(v.b_mode, v.b_val, r, c);
            end
        end
    endtask

    // Caller is at a negedge with the engine idle; returns at the negedge where done is seen.
    task automatic run(input bit big, output int cyc);
        int limit;
        limit = big ? RUN32 + 100 : RUN4 + 100;
        if (big) start32 = 1'b1; else start4 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        start4  = 1'b0;
        cyc = 1;
        while (!(big ? done32 : done4) && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_run(input string tag, input vec_t v, input int cyc,
                             input int wb, input int db, input int bb, input int runs);
        logic [7:0] exp;
        @(negedge clk);
        #1;
        check({tag, "_cycles"}, cyc, RUN4);
        check({tag, "_busy_after"}, 32'(busy4), 0);
        check({tag, "_writes"}, wr4 - wb, NS * NS * runs);
        check({tag, "_done_pulses"}, done4_cnt - db, runs);
        check({tag, "_busy_cycles"}, busy4_cnt - bb, RUN4 * runs);
        for (int i = 0; i < NS; i++) begin
            for (int j = 0; j < NS; j++) begin
                exp = (v.exp < 0) ? elem(v.b_mode, v.b_val, i, j) : 8'(v.exp);
                check($sformatf("%s_c%0d%0d", tag, i, j), 32'(c_got[i*NS+j]), 32'(exp));
            end
        end
    endtask

    initial begin
        vec_t vecs [6];
        int   cyc, wb, db, bb;

        vecs[0] = '{1, 8'd0,   2, 8'd0,   -1};
        vecs[1] = '{0, 8'd1,   0, 8'd1,   4};
        vecs[2] = '{0, 8'd255, 0, 8'd255, E255_4};
        vecs[3] = '{0, 8'd3,   0, 8'd5,   60};
        vecs[4] = '{0, 8'd200, 0, 8'd2,   E1600_4};
        vecs[5] = '{1, 8'd0,   0, 8'd7,   7};

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy4), 0);
        check("rst_done", 32'(done4), 0);
        check("rst_rd_en", 32'(m4.rd_en), 0);
        check("rst_c_we", 32'(m4.c_we), 0);
        check("rst_a_addr", 32'(m4.a_addr), 0);
        check("rst_c_data", 32'(m4.c_data), 0);
        check("rst_busy32", 32'(busy32), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full-size run: all-255 operands
        run(1'b1, cyc);
        @(negedge clk);
        #1;
        check("n32_cycles", cyc, RUN32);
        check("n32_busy_after", 32'(busy32), 0);
        check("n32_writes", wr32, ACC_N * ACC_N);
        check("n32_bad_writes", bad32, 0);
        check("n32_done_pulses", done32_cnt, 1);
        check("n32_busy_cycles", busy32_cnt, RUN32);

        for (int v = 0; v < 6; v++) begin
            load(vecs[v]);
            wb = wr4; db = done4_cnt; bb = busy4_cnt;
            run(1'b0, cyc);
            check_run($sformatf("vec%0d", v), vecs[v], cyc, wb, db, bb, 1);
        end

        // start re-pulsed mid-run must be ignored
        load(vecs[0]);
        wb = wr4; db = done4_cnt; bb = busy4_cnt;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        cyc = 1;
        while (!done4 && cyc < RUN4 + 100) begin
            start4 = (cyc == 50);
            @(negedge clk);
            cyc++;
        end
        start4 = 1'b0;
        check_run("repulse", vecs[0], cyc, wb, db, bb, 1);

        // start held through DONE: one idle cycle, then a second run
        load(vecs[5]);
        wb = wr4; db = done4_cnt; bb = busy4_cnt;
        start4 = 1'b1;
        cyc = 0;
        while (!done4 && cyc < RUN4 + 100) begin
            @(negedge clk);
            cyc++;
        end
        check("held_first_cycles", cyc, RUN4);
        @(negedge clk);
        check("held_idle_busy", 32'(busy4), 0);
        @(negedge clk);
        check("held_restart_busy", 32'(busy4), 1);
        check("held_restart_rd_en", 32'(m4.rd_en), 1);
        start4 = 1'b0;
        cyc = 1;
        while (!done4 && cyc < RUN4 + 100) begin
            @(negedge clk);
            cyc++;
        end
        check_run("held", vecs[5], cyc, wb, db, bb, 2);

        // Reset in the middle of a run, then a clean restart
        load(vecs[1]);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (49) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy4), 0);
        check("midrst_rd_en", 32'(m4.rd_en), 0);
        check("midrst_c_we", 32'(m4.c_we), 0);
        check("midrst_a_addr", 32'(m4.a_addr), 0);
        check("midrst_b_addr", 32'(m4.b_addr), 0);
        check("midrst_c_addr", 32'(m4.c_addr), 0);
        check("midrst_c_data", 32'(m4.c_data), 0);
        check("midrst_done", 32'(done4), 0);
        wb = wr4;
        repeat (3) @(negedge clk);
        check("midrst_no_writes", wr4 - wb, 0);
        rst_n = 1'b1;
        @(negedge clk);
        load(vecs[3]);
        wb = wr4; db = done4_cnt; bb = busy4_cnt;
        run(1'b0, cyc);
        check_run("restart", vecs[3], cyc, wb, db, bb, 1);

        check("write_order_errors", order4, 0);
        check("we_with_rd_en", overlap4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/acc_mac_engine.md
# acc_mac_engine

Sequential matrix-multiply core for the accelerator. It consumes the 32×32 8-bit operand matrices A and B held in the accelerator's operand buffers and produces result matrix C = A·B, one element at a time. It sits directly downstream of the bus-facing data loader: the loader fills A/B and raises `start`, and this engine reads operands through synchronous read ports. It then writes C through a byte write port that the loader reads back.

## Interface
- `N`, 32: matrix dimension; power of two, 2..32.
- `DATA_W`, 8: operand and result element width.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  level sampled in IDLE; begins a multiply.
- `busy`  out  1  high from the first RUN cycle until DONE is left.
- `done`  out  1  single-cycle pulse when the last C element has been written.
- `rd_en`  out  1  operand read strobe for the A and B buffers.
- `a_addr`  out  log2(N*N)  A index, row-major: i*N+k.
- `b_addr`  out  log2(N*N)  B index, row-major: k*N+j.
- `a_data`  in  DATA_W  A element; valid 1 cycle after `rd_en`.
- `b_data`  in  DATA_W  B element; valid 1 cycle after `rd_en`.
- `c_we`  out  1  C write strobe.
- `c_addr`  out  log2(N*N)  C index i*N+j.
- `c_data`  out  DATA_W  C element.

## Operation
- Reset value of all outputs is 0; the FSM resets to IDLE and all counters to 0.
- FSM states and transitions:
  - IDLE: `start`=1 → RUN with i=j=k=0.
  - RUN: issues `rd_en`=1 and addresses for the current k, then k++. After issuing k=N-1 → DRAIN.
  - DRAIN: accumulates the final product; `rd_en`=0. → WRITE.
  - WRITE: `c_we`=1, `c_addr`=i*N+j, `c_data`=result. The accumulator is cleared and j++ (wrapping into i++). If the element just written was (N-1,N-1) → DONE; otherwise → RUN with k=0.
  - DONE: `done`=1 for one cycle. → IDLE.
- Accumulation:
  - Operands are unsigned.
  - Products are accumulated in ACC_W = 2*DATA_W + log2(N) bits (21 bits at defaults), so the accumulator never overflows.
  - The accumulator adds `a_data*b_data` in the cycle after each `rd_en`; the first product of an element overwrites the accumulator rather than adding to it.
- Result width reduction is set by the configuration macro (see Configuration).
- `start` is ignored in every state except IDLE. `start` held high across DONE begins a new run on the cycle after IDLE is entered.
- Reset asserted mid-run:
  - Immediate abort: all outputs go to 0 and no further writes occur.
  - C elements already written are not recomputed.
- `c_we` is asserted exactly N*N times per run, never with `rd_en`.

## Timing
- Per element: N RUN + 1 DRAIN + 1 WRITE = N+2 cycles.
- Full run: N*N*(N+2) cycles from the first RUN cycle to the last WRITE; 34816 at defaults. `done` follows one cycle later.
- `busy` rises in the cycle after `start` is sampled in IDLE. It falls in the cycle after DONE.
- Operand read latency is exactly 1 cycle; the engine has no backpressure input.

## Configuration
- `ACC_SATURATE_EN` defined: `c_data` = min(acc, 2^DATA_W−1), i.e. unsigned saturation.
- `ACC_SATURATE_EN` undefined: `c_data` = acc[DATA_W-1:0], i.e. modulo truncation.

## Structure
- Package `acc_pkg` holds:
  - constants ACC_N, ACC_DATA_W, ACC_ACC_W, ACC_IDX_W, ACC_ADDR_W;
  - the FSM enum `acc_state_e` (IDLE, RUN, DRAIN, WRITE, DONE);
  - the reduction function `acc_reduce()`, guarded by `ACC_SATURATE_EN`.
- One sub-module, `acc_addr_gen`: the nested i/j/k counters with wrap flags, plus the a/b/c address formation. The FSM and MAC datapath stay in `acc_mac_engine`.

## Test plan
- A = identity, B[r][c] = r+c → C == B. 1024 writes seen, each address written once in ascending order.
- A = B = all 1 → every C element = 32 (0x20).
- A = B = all 255 → with `ACC_SATURATE_EN` every C element = 255; without it every C element = 0x20 (0x1FC020 truncated).
- Single start → `done` pulse exactly 34817 cycles after `start` is sampled. `busy` high for 34817 cycles and low afterwards.
- `start` pulsed again at cycle 100 of a run → ignored: same cycle count, 1024 writes, one `done`.
- `rst_n` low at cycle 5000, released, then restart → all outputs 0 during reset. The restarted run produces correct C and a full-length run.
